iir_lowpass_multi: RTL

Time-multiplexed, multi-channel single-pole IIR low-pass filter with a runtime-selectable gain shift and valid/ready streaming on both sides. Per-channel accumulators are held in a register array, with one sample processed per cycle. A gain change or an explicit clear request starts an automatic flush sweep of all channel states. It sits between multi-channel ADC/decimator front-ends and downstream control or telemetry logic.

---
 rtl/iir_lowpass_multi_if.sv | 46 ++++
 rtl/iir_lowpass_multi.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/iir_lowpass_multi_if.sv
// -----------------------------------------------------------------------------
// iir_lowpass_multi_if
// Stream and control bundle for iir_lowpass_multi.
//
// Handshake: a beat transfers on a rising clk edge where valid && ready are
// both high. A source holds valid and its payload until that edge. Ready may
// be asserted without valid and never depends on valid on the same side.
//
// Signals
//   gain      filter shift k (clamped to MAX_GAIN inside the filter)
//   clear_req single-cycle pulse, flush every channel accumulator
//   in_*      input sample stream (valid/ready/ch/data)
//   out_*     filtered sample stream (valid/ready/ch/data)
//   busy      flush sweep in progress
// Modports: slave = filter side, master = producer/consumer side.
// -----------------------------------------------------------------------------
interface iir_lowpass_multi_if #(
   parameter int WIDTH    = 16,
   parameter int CHANNELS = 4,
   parameter int MAX_GAIN = 8
);
   localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int G_W  = $clog2(MAX_GAIN + 1);

   logic [G_W-1:0]          gain;
   logic                    clear_req;
   logic                    in_valid;
   logic                    in_ready;
   logic [CH_W-1:0]         in_ch;
   logic signed [WIDTH-1:0] in_data;
   logic                    out_valid;
   logic                    out_ready;
   logic [CH_W-1:0]         out_ch;
   logic signed [WIDTH-1:0] out_data;
   logic                    busy;

   modport slave (
      input  gain, clear_req, in_valid, in_ch, in_data, out_ready,
      output in_ready, out_valid, out_ch, out_data, busy
   );

   modport master (
      output gain, clear_req, in_valid, in_ch, in_data, out_ready,
      input  in_ready, out_valid, out_ch, out_data, busy
   );
endinterface

// File: rtl/iir_lowpass_multi.sv
// -----------------------------------------------------------------------------
// iir_lowpass_multi
// Time-multiplexed single-pole IIR low-pass over CHANNELS independent
// channels, one sample per cycle:
//   acc[ch] <= acc[ch] + in - (acc[ch] >>> k);  out = acc_new >>> k
// A gain change or clear_req starts a CHANNELS-cycle sweep that zeroes every
// accumulator; input is blocked while it runs.
//
// Ports
//   clk          clock
//   rst          synchronous active-high reset
//   bus          iir_lowpass_multi_if.slave (gain, clear, in/out streams, busy)
//   o_dbg_state  current FSM state (0 = RUN, 1 = CLEAR)
// -----------------------------------------------------------------------------
module iir_lowpass_multi #(
   parameter int WIDTH    = 16,
   parameter int CHANNELS = 4,
   parameter int MAX_GAIN = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   iir_lowpass_multi_if.slave    bus,
   output logic                  o_dbg_state
);
   localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int G_W   = $clog2(MAX_GAIN + 1);
   localparam int ACC_W = WIDTH + MAX_GAIN;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [CH_W-1:0]         r_idx;
   logic [CH_W-1:0]         w_idx_nxt;
   logic                    w_clr_en;
   logic [G_W-1:0]          r_gain_q;
   logic [G_W-1:0]          w_gain_clamped;
   logic signed [ACC_W-1:0] r_acc [CHANNELS];
   logic                    r_out_valid;
   logic [CH_W-1:0]         r_out_ch;
   logic signed [WIDTH-1:0] r_out_data;

   logic                    w_restart;
   logic                    w_in_ready;
   logic                    w_accept;
   logic                    w_ch_ok;
   logic signed [ACC_W-1:0] w_acc_cur;
   logic signed [ACC_W-1:0] w_in_sext;
   logic signed [ACC_W-1:0] w_acc_shr;
   logic signed [ACC_W-1:0] w_acc_new;
   logic signed [ACC_W-1:0] w_out_full;

   assign w_gain_clamped = (bus.gain > G_W'(MAX_GAIN)) ? G_W'(MAX_GAIN) : bus.gain;

   // Any clear request or effective gain change (re)starts the sweep, in
   // either state, so the sweep always finishes with every channel zeroed.
   assign w_restart  = bus.clear_req || (w_gain_clamped != r_gain_q);

   assign w_in_ready = (r_state == ST_RUN) && (!r_out_valid || bus.out_ready);
   assign w_accept   = bus.in_valid && w_in_ready;

   // Out-of-range channel ids are accepted but have no effect.
   assign w_ch_ok    = {1'b0, bus.in_ch} < (CH_W + 1)'(CHANNELS);

   assign w_acc_cur  = w_ch_ok ? r_acc[bus.in_ch] : '0;
   assign w_in_sext  = {{MAX_GAIN{bus.in_data[WIDTH-1]}}, bus.in_data};
   assign w_acc_shr  = w_acc_cur >>> r_gain_q;
   assign w_acc_new  = w_acc_cur + w_in_sext - w_acc_shr;
   // |acc_new| <= 2^k * 2^(WIDTH-1), so the shifted value fits in WIDTH bits.
   assign w_out_full = w_acc_new >>> r_gain_q;

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_RUN;
         r_idx    <= '0;
         r_gain_q <= w_gain_clamped;
      end else begin
         r_state  <= w_state_nxt;
         r_idx    <= w_idx_nxt;
         if (w_restart) begin
            r_gain_q <= w_gain_clamped;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_clr_en    = 1'b0;
      case (r_state)
         ST_RUN: begin
            if (w_restart) begin
               w_state_nxt = ST_CLEAR;
               w_idx_nxt   = '0;
            end
         end
         ST_CLEAR: begin
            w_clr_en = 1'b1;
            if (w_restart) begin
               w_idx_nxt = '0;
            end else if (r_idx == CH_W'(CHANNELS - 1)) begin
               w_state_nxt = ST_RUN;
               w_idx_nxt   = '0;
            end else begin
               w_idx_nxt = r_idx + 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_RUN;
            w_idx_nxt   = '0;
         end
      endcase
   end

   // ---------------- Datapath ----------------
   // Accept only happens in RUN and clearing only in CLEAR, so the two
   // accumulator writes never collide.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < CHANNELS; i++) begin
            r_acc[i] <= '0;
         end
         r_out_valid <= 1'b0;
         r_out_ch    <= '0;
         r_out_data  <= '0;
      end else begin
         if (w_clr_en) begin
            r_acc[r_idx] <= '0;
         end
         if (w_accept && w_ch_ok) begin
            r_acc[bus.in_ch] <= w_acc_new;
            r_out_valid      <= 1'b1;
            r_out_ch         <= bus.in_ch;
            r_out_data       <= w_out_full[WIDTH-1:0];
         end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_ch    = r_out_ch;
   assign bus.out_data  = r_out_data;
   assign bus.busy      = (r_state == ST_CLEAR);
   assign o_dbg_state   = r_state;
endmodule
